// File: rtl/sweep_sequencer_pkg.sv
// Shared mode codes and FSM state encoding for the triangle sweep sequencer
// and its up/down counter datapath.
package sweep_sequencer_pkg;

   localparam logic [1:0] MODE_UP   = 2'd0;
   localparam logic [1:0] MODE_DN   = 2'd1;
   localparam logic [1:0] MODE_HOLD = 2'd2;
   localparam logic [1:0] MODE_CLR  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      UP    = 2'd2,
      DOWN  = 2'd3
   } state_t;

endpackage

// File: rtl/sweep_sequencer_updown_counter_core.sv
// N-bit counter datapath: steps up, down, holds or clears on each CLK edge
// according to the 2-bit mode code s.
module updown_counter_core
   import sweep_sequencer_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic [1:0]   s,
   output logic [N-1:0] q
);

   localparam logic [N-1:0] ONE_N = N'(1);

   logic [N-1:0] q_reg;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         q_reg <= '0;
      end else begin
         case (s)
            MODE_UP:  q_reg <= q_reg + ONE_N;
            MODE_DN:  q_reg <= q_reg - ONE_N;
            MODE_CLR: q_reg <= '0;
            default:  q_reg <= q_reg;
         endcase
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/sweep_sequencer.sv
// Triangle sweep controller: clears the counter, ramps 0->hi, then bounces
// between lo and hi for a programmed number of periods (0 = until stop).
module sweep_sequencer
   import sweep_sequencer_pkg::*;
#(
   parameter int N = 8,
   parameter int C = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         start,
   input  logic         stop,
   input  logic         pause,
   input  logic [N-1:0] lo,
   input  logic [N-1:0] hi,
   input  logic [C-1:0] cycles,
   output logic [1:0]   s,
   output logic [N-1:0] q,
   output logic         dir,
   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam logic [N-1:0] ONE_N   = N'(1);
   localparam logic [C-1:0] ONE_C   = C'(1);
   localparam logic [C-1:0] CNT_MAX = '1;

   state_t       state_reg;
   logic [N-1:0] lo_reg;
   logic [N-1:0] hi_reg;
   logic [C-1:0] cycles_reg;
   logic [C-1:0] period_reg;
   logic [C-1:0] period_next;
   logic         done_reg;
   logic         err_reg;
   logic         top_hit;
   logic         bot_hit;

   // Turn decisions look at the count the coming edge will produce.
   assign top_hit     = (q == hi_reg - ONE_N);
   assign bot_hit     = (q == lo_reg + ONE_N);
   assign period_next = (period_reg == CNT_MAX) ? period_reg : period_reg + ONE_C;

   assign busy = (state_reg != IDLE);
   assign dir  = (state_reg == UP);
   assign done = done_reg;
   assign err  = err_reg;

   // Stop and pause must freeze q on the very edge they are sampled.
   always_comb begin
      s = MODE_HOLD;
      if (busy && !stop) begin
         case (state_reg)
            CLEAR:   s = MODE_CLR;
            UP:      s = pause ? MODE_HOLD : MODE_UP;
            DOWN:    s = pause ? MODE_HOLD : MODE_DN;
            default: s = MODE_HOLD;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg  <= IDLE;
         lo_reg     <= '0;
         hi_reg     <= '0;
         cycles_reg <= '0;
         period_reg <= '0;
         done_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start && !stop) begin
                  if (hi > lo) begin
                     lo_reg     <= lo;
                     hi_reg     <= hi;
                     cycles_reg <= cycles;
                     period_reg <= '0;
                     state_reg  <= CLEAR;
                  end else begin
                     err_reg <= 1'b1;
                  end
               end
            end
            CLEAR: state_reg <= stop ? IDLE : UP;
            UP: begin
               if (stop)
                  state_reg <= IDLE;
               else if (!pause && top_hit)
                  state_reg <= DOWN;
            end
            DOWN: begin
               if (stop) begin
                  state_reg <= IDLE;
               end else if (!pause && bot_hit) begin
                  period_reg <= period_next;
                  if (cycles_reg != '0 && period_next == cycles_reg) begin
                     state_reg <= IDLE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= UP;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   updown_counter_core #(
      .N (N)
   ) u_core (
      .CLK (CLK),
      .RST (RST),
      .s   (s),
      .q   (q)
   );

endmodule

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
- Controller that sequences an up/down/hold/clear counter datapath to produce a bounded triangle sweep.
- After a clear, the count ramps from 0 up to HI, then down to LO, then bounces between LO and HI for a programmed number of periods.
- Drives the counter's 2-bit mode code and exposes the count, status and completion flags.
- Sits between a control/register interface and any block that consumes a ramping address or level.

Parameters:
N, 8, counter/bound width in bits
C, 8, width of period-count field

Ports:
CLK  in  1  clock, rising-edge
RST  in  1  asynchronous active-low reset
start  in  1  begin sweep; sampled only in IDLE
stop  in  1  abort sweep; highest priority
pause  in  1  freeze count while high
lo  in  N  lower turn-around bound, latched at start
hi  in  N  upper turn-around bound, latched at start
cycles  in  C  number of full HI->LO periods; 0 = run until stop
s  out  2  counter mode: 0 up, 1 down, 2 hold, 3 clear
q  out  N  current count
dir  out  1  1 = counting up, 0 = down/other
busy  out  1  high in CLEAR/UP/DOWN
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on rejected start

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-low.
- Reset values: state IDLE, q=0, period count=0, s=2, dir=0, busy=0, done=0, err=0. Latched lo/hi/cycles are cleared to 0.
- s is a Moore output of the state register. The pause override in UP/DOWN forces s=2.
- q is registered and updates on the CLK edge per s: +1, -1, hold, or 0.
- States and mode outputs:
  - IDLE: s=2.
  - CLEAR: s=3.
  - UP: s=0, dir=1.
  - DOWN: s=1.
- Transitions:
  - IDLE, start=1 with valid bounds: latch lo/hi/cycles, clear period count, go to CLEAR.
  - IDLE, start=1 with hi<=lo: stay IDLE, err=1 for one cycle, nothing latched.
  - CLEAR -> UP unconditionally. q becomes 0 on that edge.
  - UP: on the edge where q becomes hi (q==hi-1, no pause), go to DOWN.
  - DOWN: on the edge where q becomes lo (q==lo+1, no pause), increment the period count.
    - If cycles!=0 and the new count==cycles: go to IDLE and pulse done.
    - Otherwise go to UP.
- Turn-around decisions use the next count, so q never overshoots hi or undershoots lo.
- First ramp is 0->hi. When lo=0, the first period is the same as the others.
- pause=1 in UP/DOWN: s=2, q and state unchanged, busy stays 1.
- pause=1 in CLEAR is ignored; the clear completes.
- stop=1 in any busy state: next edge goes to IDLE, s=2, q retains its value, no done pulse.
- Priority: stop > pause > boundary turn > normal step.
- start while busy is ignored. start and stop asserted together in IDLE: start is ignored.
- Period count saturates at 2^C-1 when cycles=0. It is free-running and not observable.
- Asynchronous reset mid-sweep returns to IDLE immediately with q=0.

Decomposition:
- Shared package holds:
  - mode codes MODE_UP=0, MODE_DN=1, MODE_HOLD=2, MODE_CLR=3;
  - state encoding IDLE/CLEAR/UP/DOWN.
- One sub-module, updown_counter_core: N-bit register with async active-low reset, input s[1:0], output q. It is the datapath.
- sweep_sequencer holds the FSM, bound latches, period counter and compare logic.

Test Plan:
1. N=4, lo=2, hi=5, cycles=2, start pulse -> CLEAR for 1 cycle; q follows 0,1,2,3,4,5,4,3,2,3,4,5,4,3,2; done pulses the cycle after q first becomes 2 on the second descent; busy falls with it; s=2 after.
2. Same setup, pause held 3 cycles while q=3 on the ascent -> q stays 3 for 3 cycles with s=2, then resumes 4,5 with no lost or extra steps.
3. lo=4, hi=4, start -> err pulses 1 cycle, busy stays 0, q unchanged. Repeat with lo=6, hi=3 -> same.
4. cycles=0, lo=1, hi=3 -> q oscillates 3,2,1,2,3... for at least 20 cycles; stop at q=2 -> IDLE, q holds 2, no done pulse.
5. stop and pause both asserted at the cycle q==hi-1 -> IDLE, q=hi-1, no turn to DOWN.
6. RST low mid-descent (q=4) -> q=0, busy=0 asynchronously. A start after release runs a clean sweep from CLEAR.
